// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  // Explicit wrap so non-power-of-2 requester counts rotate correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the pointer.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int            w_pos;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IW'(w_pos);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte-stream sources; grants are held for a
// whole message and revoked if the owner stalls for TIMEOUT_CYC cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [BYTE_W-1:0]         o_tx_data,
  output logic                      o_tx_data_valid,
  input  logic                      i_tx_data_ready,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_gidx, r_rr_ptr, w_pick_idx, w_next_ptr;
  logic              w_pick_found;
  logic [BYTE_W-1:0] r_tx_data, w_sel_data;
  logic              r_tx_valid, r_last_flag, r_timeout_err;
  logic              w_sel_valid, w_sel_last;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_xfer, w_req_hs, w_tx_hs, w_done, w_stall, w_timeout;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == IW'(i)) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign w_xfer     = (r_state == ST_XFER);
  assign w_req_hs   = w_xfer & ~r_tx_valid & w_sel_valid;
  assign w_tx_hs    = r_tx_valid & i_tx_data_ready;
  assign w_done     = w_tx_hs & r_last_flag;
  // The stall counter only runs when the owner, not uart_tx, is holding things up.
  assign w_stall    = w_xfer & ~r_tx_valid & ~w_sel_valid;
  assign w_timeout  = (TIMEOUT_CYC > 0) && w_stall && (r_stall_cnt == TO_LAST);
  assign w_next_ptr = IW'(wrap_inc(int'(r_gidx), NUM_REQ));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_found) w_state_nxt = ST_XFER;
      ST_XFER: if (w_done || w_timeout) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = w_xfer;
    o_grant     = '0;
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_xfer && (r_gidx == IW'(i))) begin
        o_grant[i]     = 1'b1;
        o_req_ready[i] = ~r_tx_valid;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_last_flag   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_pick_found) begin
          r_gidx      <= w_pick_idx;
          r_stall_cnt <= '0;
        end
      end else begin
        if (w_req_hs) begin
          r_tx_data   <= w_sel_data;
          r_last_flag <= w_sel_last;
          r_tx_valid  <= 1'b1;
          r_stall_cnt <= '0;
        end
        if (w_tx_hs) begin
          r_tx_valid <= 1'b0;
          if (r_last_flag) r_rr_ptr <= w_next_ptr;
        end
        if (w_timeout) begin
          r_timeout_err <= 1'b1;
          r_rr_ptr      <= w_next_ptr;
          r_stall_cnt   <= '0;
        end else if (w_stall) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_data_valid = r_tx_valid;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: message ordering, rotating priority,
// stall timeout, reset behaviour and long uart_tx back-pressure.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [NR*8-1:0] req_data;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_ready, busy, timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .o_tx_data       (tx_data),
    .o_tx_data_valid (tx_valid),
    .i_tx_data_ready (tx_ready),
    .o_grant         (grant),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0]    src_mem [NR][8];
  int            src_len [NR];
  int            src_pos [NR];
  logic [7:0]    log_data [32];
  logic [NR-1:0] log_grant [32];
  int            log_cyc [32];
  int            log_n, te_n, cyc, tx_delay, vcnt, ng_viol;
  int            te_cyc [8];

  task automatic apply_sources();
    for (int i = 0; i < NR; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src_mem[i][src_pos[i]][8];
        req_data[i*8 +: 8] = src_mem[i][src_pos[i]][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic update_ready();
    if (tx_valid) vcnt++;
    else vcnt = 0;
    tx_ready = tx_valid && (vcnt > tx_delay);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    log_n = 0;
    te_n  = 0;
    apply_sources();
  endtask

  // One clock: observe handshakes before the edge, advance sources after it.
  task automatic step();
    logic [NR-1:0] hs;
    hs = req_valid & req_ready;
    if ((req_ready & ~grant) != '0) ng_viol++;
    if (tx_valid && tx_ready && log_n < 32) begin
      log_data[log_n]  = tx_data;
      log_grant[log_n] = grant;
      log_cyc[log_n]   = cyc + 1;
      log_n++;
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (hs[i]) src_pos[i]++;
    apply_sources();
    update_ready();
    if (timeout_err && te_n < 8) begin
      te_cyc[te_n] = cyc;
      te_n++;
    end
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    tx_delay = 0;
    vcnt     = 0;
    tx_ready = 1'b0;
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_ready = 1'b0;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b busy=%b ready=%b expected 0000/0/0000", grant, busy, req_ready);
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: valid=%b data=%h terr=%b expected 0/00/0", tx_valid, tx_data, timeout_err);
    end
    reset_dut();
    src_mem[0][0] = {1'b1, 8'h5A};
    src_len[0]    = 1;
    apply_sources();
    #1;
    checks++;
    if (req_ready !== 4'b0000 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_accept: ready=%b grant=%b expected 0000/0000", req_ready, grant);
    end
    reset_dut();
  endtask

  task automatic test_hi();
    int gbad = 0;
    reset_dut();
    tx_delay = 3;
    src_mem[0][0] = {1'b0, 8'h48};
    src_mem[0][1] = {1'b1, 8'h69};
    src_len[0]    = 2;
    apply_sources();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL hi_grant_c0: got %b expected 0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL hi_grant_c1: got %b expected 0001", grant);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL hi_ready_c1: got %b expected 0001", req_ready);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
      errors++;
      $display("FAIL hi_tx_c2: valid=%b data=%h expected 1/48", tx_valid, tx_data);
    end
    for (int k = 0; k < 40 && log_n < 2; k++) begin
      step();
      if (busy && grant !== 4'b0001) gbad++;
    end
    checks++;
    if (log_n !== 2) begin
      errors++;
      $display("FAIL hi_count: got %0d bytes expected 2", log_n);
    end
    checks++;
    if (log_data[0] !== 8'h48 || log_data[1] !== 8'h69) begin
      errors++;
      $display("FAIL hi_bytes: got %h %h expected 48 69", log_data[0], log_data[1]);
    end
    checks++;
    if (log_grant[0] !== 4'b0001 || log_grant[1] !== 4'b0001 || gbad !== 0) begin
      errors++;
      $display("FAIL hi_grant: got %b %b bad=%0d expected 0001 0001 0", log_grant[0], log_grant[1], gbad);
    end
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL hi_idle: busy=%b grant=%b expected 0/0000", busy, grant);
    end
  endtask

  // Pointer should now be 1, so source 1 beats source 0.
  task automatic test_rr_pointer();
    clear_sources();
    tx_delay = 0;
    src_mem[0][0] = {1'b1, 8'hA0};
    src_mem[1][0] = {1'b1, 8'hB1};
    src_len[0] = 1;
    src_len[1] = 1;
    apply_sources();
    for (int k = 0; k < 30 && log_n < 2; k++) step();
    checks++;
    if (log_n !== 2 || log_data[0] !== 8'hB1 || log_data[1] !== 8'hA0) begin
      errors++;
      $display("FAIL rr_ptr_order: n=%0d got %h %h expected B1 A0", log_n, log_data[0], log_data[1]);
    end
    checks++;
    if (log_grant[0] !== 4'b0010 || log_grant[1] !== 4'b0001) begin
      errors++;
      $display("FAIL rr_ptr_grant: got %b %b expected 0010 0001", log_grant[0], log_grant[1]);
    end
  endtask

  task automatic test_two_sources();
    logic [7:0]    exp_d [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    logic [NR-1:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
    reset_dut();
    tx_delay = 1;
    for (int j = 0; j < 3; j++) begin
      src_mem[0][j] = {(j == 2), 8'h10 + 8'(j)};
      src_mem[2][j] = {(j == 2), 8'h20 + 8'(j)};
    end
    src_len[0] = 3;
    src_len[2] = 3;
    apply_sources();
    for (int k = 0; k < 80 && log_n < 6; k++) step();
    checks++;
    if (log_n !== 6) begin
      errors++;
      $display("FAIL two_src_count: got %0d expected 6", log_n);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (log_data[j] !== exp_d[j] || log_grant[j] !== exp_g[j]) begin
        errors++;
        $display("FAIL two_src_byte%0d: got %h/%b expected %h/%b", j, log_data[j], log_grant[j], exp_d[j], exp_g[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]    ed;
    logic [NR-1:0] eg;
    reset_dut();
    tx_delay = 0;
    for (int i = 0; i < NR; i++) begin
      src_mem[i][0] = {1'b1, 8'h30 + 8'(i)};
      src_mem[i][1] = {1'b1, 8'h40 + 8'(i)};
      src_len[i]    = 2;
    end
    apply_sources();
    for (int k = 0; k < 80 && log_n < 8; k++) step();
    checks++;
    if (log_n !== 8) begin
      errors++;
      $display("FAIL rr_count: got %0d expected 8", log_n);
    end
    for (int j = 0; j < 8; j++) begin
      eg = 4'b0001 << (j % 4);
      ed = ((j < 4) ? 8'h30 : 8'h40) + 8'(j % 4);
      checks++;
      if (log_data[j] !== ed || log_grant[j] !== eg) begin
        errors++;
        $display("FAIL rr_msg%0d: got %h/%b expected %h/%b", j, log_data[j], log_grant[j], ed, eg);
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    tx_delay = 0;
    src_mem[1][0] = {1'b0, 8'h55};
    src_mem[2][0] = {1'b1, 8'h77};
    src_len[1] = 1;
    src_len[2] = 1;
    apply_sources();
    for (int k = 0; k < 60 && te_n < 1; k++) step();
    checks++;
    if (te_n !== 1) begin
      errors++;
      $display("FAIL to_pulse_seen: got %0d pulses expected 1", te_n);
    end
    checks++;
    if (log_n < 1 || log_data[0] !== 8'h55 || log_grant[0] !== 4'b0010) begin
      errors++;
      $display("FAIL to_first_byte: n=%0d got %h/%b expected 55/0010", log_n, log_data[0], log_grant[0]);
    end
    checks++;
    if (te_cyc[0] - log_cyc[0] !== 16) begin
      errors++;
      $display("FAIL to_delay: got %0d cycles expected 16", te_cyc[0] - log_cyc[0]);
    end
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_revoke: grant=%b busy=%b expected 0000/0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 4'b0100 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_next_grant: grant=%b terr=%b expected 0100/0", grant, timeout_err);
    end
    for (int k = 0; k < 30 && log_n < 2; k++) step();
    checks++;
    if (log_n !== 2 || log_data[1] !== 8'h77 || log_grant[1] !== 4'b0100 || te_n !== 1) begin
      errors++;
      $display("FAIL to_src2_msg: n=%0d got %h/%b te=%0d expected 2 77/0100 1", log_n, log_data[1], log_grant[1], te_n);
    end
  endtask

  task automatic test_reset_mid();
    clear_sources();
    tx_delay = 1000000;
    src_mem[0][0] = {1'b0, 8'hC0};
    src_mem[0][1] = {1'b1, 8'hC1};
    src_len[0]    = 2;
    apply_sources();
    for (int k = 0; k < 20 && tx_valid !== 1'b1; k++) step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hC0) begin
      errors++;
      $display("FAIL mid_pending: valid=%b data=%h expected 1/C0", tx_valid, tx_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_async_reset: valid=%b grant=%b busy=%b data=%h expected 0/0000/0/00", tx_valid, grant, busy, tx_data);
    end
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    tx_delay = 0;
    update_ready();
    src_mem[1][0] = {1'b1, 8'hD1};
    src_mem[3][0] = {1'b1, 8'hD3};
    src_len[1] = 1;
    src_len[3] = 1;
    apply_sources();
    for (int k = 0; k < 30 && log_n < 2; k++) step();
    checks++;
    if (log_n !== 2 || log_data[0] !== 8'hD1 || log_data[1] !== 8'hD3) begin
      errors++;
      $display("FAIL mid_after_order: n=%0d got %h %h expected D1 D3", log_n, log_data[0], log_data[1]);
    end
    checks++;
    if (log_grant[0] !== 4'b0010 || log_grant[1] !== 4'b1000) begin
      errors++;
      $display("FAIL mid_after_grant: got %b %b expected 0010 1000", log_grant[0], log_grant[1]);
    end
  endtask

  task automatic test_long_stall();
    int bad = 0;
    clear_sources();
    tx_delay = 100000;
    src_mem[2][0] = {1'b0, 8'hE2};
    src_mem[2][1] = {1'b1, 8'hE3};
    src_len[2]    = 2;
    apply_sources();
    for (int k = 0; k < 20 && tx_valid !== 1'b1; k++) step();
    for (int k = 0; k < 1000; k++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hE2 || req_ready !== 4'b0000 || timeout_err !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (te_n !== 0) begin
      errors++;
      $display("FAIL stall_no_timeout: got %0d pulses expected 0", te_n);
    end
    tx_delay = 0;
    for (int k = 0; k < 40 && log_n < 2; k++) step();
    checks++;
    if (log_n !== 2 || log_data[0] !== 8'hE2 || log_data[1] !== 8'hE3 || log_grant[1] !== 4'b0100) begin
      errors++;
      $display("FAIL stall_drain: n=%0d got %h %h/%b expected E2 E3/0100", log_n, log_data[0], log_data[1], log_grant[1]);
    end
  endtask

  task automatic test_nongranted();
    checks++;
    if (ng_viol !== 0) begin
      errors++;
      $display("FAIL nongranted_ready: got %0d cycles expected 0", ng_viol);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cyc     = 0;
    ng_viol = 0;
    test_reset();
    test_hi();
    test_rr_pointer();
    test_two_sources();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_long_stall();
    test_nongranted();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ independent byte-stream sources.
- Arbitrates round-robin at message boundaries: a granted source keeps the transmitter until its byte marked last is accepted, so messages never interleave.
- Sits between the application FSMs (status reporter, clock-time dump, echo path) and uart_tx's tx_data/tx_data_valid/tx_data_ready handshake.
- Includes a stall timeout so a dead source cannot lock the UART.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 5000000, clk cycles a granted source may leave its valid low between bytes before the grant is revoked; 0 disables the timeout.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-source byte valid.
- req_data  in  NUM_REQ*8  per-source byte; source i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a message; sampled with req_data.
- req_ready  out  NUM_REQ  per-source accept strobe; a byte is consumed when req_valid[i] and req_ready[i] are both high.
- tx_data  out  8  byte to uart_tx.
- tx_data_valid  out  1  to uart_tx.
- tx_data_ready  in  1  from uart_tx.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high while in XFER.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE, grant=0, tx_data=0, tx_data_valid=0, busy=0, timeout_err=0, rr_ptr=0, stall counter=0, last_flag=0. req_ready is combinational and is therefore 0.
- IDLE:
  - If any req_valid is high, choose the first asserted index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register that index into grant, set busy=1, go to XFER on the same edge.
  - No byte is accepted in IDLE.
- XFER, load:
  - req_ready[i] = (state==XFER) & grant[i] & !tx_data_valid.
  - On a req handshake: tx_data <= req_data[g], last_flag <= req_last[g], tx_data_valid <= 1, stall counter cleared.
- XFER, drain:
  - tx_data and tx_data_valid are held stable until tx_data_ready is high.
  - On tx_data_valid & tx_data_ready: tx_data_valid <= 0.
  - If last_flag is set: state becomes IDLE, grant=0, busy=0, rr_ptr <= g+1 mod NUM_REQ.
  - Otherwise remain in XFER.
- Throughput: at most 1 byte per 2 clk, well above the 115200-baud line rate.
- Latency: req_valid rising in IDLE at cycle 0 → grant at cycle 1 → req_ready at cycle 1 → tx_data_valid at cycle 2.
- Stall timeout:
  - In XFER with tx_data_valid=0 and req_valid[g]=0, the counter increments each clk.
  - When it reaches TIMEOUT_CYC-1: pulse timeout_err, go to IDLE, grant=0, rr_ptr <= g+1.
  - The counter is cleared on any accepted byte and on entry to XFER.
  - The counter never runs while a byte waits on uart_tx.
- Boundary cases:
  - Non-granted sources see req_ready=0 regardless of req_valid.
  - A single-byte message (valid & last together) is legal.
  - Simultaneous requests are resolved strictly by the rotating priority.
  - A source deasserting valid mid-message is a stall, not an abort.
  - Changing req_data/req_last while valid is high and ready is low is illegal input.
  - Width: rr_ptr and the index are $clog2(NUM_REQ) bits; the wrap from NUM_REQ-1 goes to 0 explicitly, not by overflow, so non-power-of-2 NUM_REQ works.
- Reset mid-message: tx_data_valid drops immediately; a byte already latched inside uart_tx is uart_tx's concern. The top level drives uart_tx rst_n = ~reset so both reset together.

Decomposition:
- Shared package/header: state encodings ST_IDLE=0, ST_XFER=1; constant BYTE_W=8.
- One natural sub-module, rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: found flag, index.
  - Reusable by the later display-bus arbiter.

Test Plan:
- Single source 0 sends "Hi" (0x48 last=0, 0x69 last=1), tx_data_ready asserted 3 cycles after each valid → tx sees 0x48 then 0x69; grant=0001 throughout; returns to IDLE; rr_ptr=1.
- Sources 0 and 2 request together from reset, each with a 3-byte message → full message from 0, then full message from 2; no interleave; grant 0001 → 0100.
- All 4 request continuously with 1-byte messages → grant order 0,1,2,3,0,1; each grant lasts until its tx handshake.
- TIMEOUT_CYC=16; source 1 sends one byte with last=0 then drops valid → timeout_err pulses exactly 16 cycles after the byte's tx handshake; grant clears; a pending source 2 is granted next cycle.
- reset asserted mid-message with tx_data_valid=1 → tx_data_valid, grant, busy go 0 asynchronously; after release, a fresh request from source 3 is granted starting from rr_ptr=0 priority.
- tx_data_ready held low 1000 cycles while tx_data_valid=1 → tx_data stable, no req_ready, no timeout_err.
